// File: rtl/ddk_data_tx.sv
`default_nettype none
// ============================================================================
// Module      : ddk_data_tx
// Description : Core-to-MCU parallel readback port. Words from ddk_core are
//               buffered in a FIFO. The MCU reads them back over the shared
//               DATA pad bus using DataRe (level) and DataClk (rising edge
//               pops one word). The FPGA drives DATA only while DataRe is high.
// Optional    : `define DDK_DATA_TX_UNDERRUN_EN adds the underrun flag, the
//               saturating underrun counter and their clear input.
// Ports       : clk, rst (sync, active-low)
//               wr_data/wr_en/wr_full/wr_drop/level : core-side write port
//               DataClk/DataRe (async)              : MCU read strobes
//               DATA_OUT/DATA_OE                    : DATA pad drive
//               DataRdy                             : FIFO non-empty to MCU
//               underrun/underrun_cnt/clr           : optional underrun status
// Revision    : 1.0 - initial release
// ============================================================================
module ddk_data_tx #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic                     wr_drop,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     DataClk,
    input  logic                     DataRe,
    output logic [WIDTH-1:0]         DATA_OUT,
    output logic                     DATA_OE,
`ifdef DDK_DATA_TX_UNDERRUN_EN
    output logic                     underrun,
    output logic [7:0]               underrun_cnt,
    input  logic                     clr,
`endif
    output logic                     DataRdy
);

    localparam int                c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL_LVL = (c_AW+1)'(DEPTH);
    localparam logic [c_AW-1:0]   c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]     c_LVL_ONE  = (c_AW+1)'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_DRIVE = 2'd2;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wp;
    logic [c_AW-1:0]  r_rp;
    logic [c_AW:0]    r_level;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data_out;
    logic             r_was_empty;
    logic             r_rdy;
    logic             r_wr_drop;

    // Two-flop synchronizers plus an extra stage on DataClk for edge detect
    logic r_clk_meta, r_clk_s, r_clk_q;
    logic r_re_meta, r_re_s;

    logic w_full, w_empty, w_push, w_rise, w_pop;

    assign w_full  = (r_level == c_FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = wr_en & ~w_full;
    assign w_rise  = r_clk_s & ~r_clk_q;
    // Deasserted DataRe has priority: a strobe seen while leaving DRIVE is ignored
    assign w_pop   = (r_state == c_DRIVE) & r_re_s & w_rise & ~w_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_meta <= 1'b0;
            r_clk_s    <= 1'b0;
            r_clk_q    <= 1'b0;
            r_re_meta  <= 1'b0;
            r_re_s     <= 1'b0;
        end else begin
            r_clk_meta <= DataClk;
            r_clk_s    <= r_clk_meta;
            r_clk_q    <= r_clk_s;
            r_re_meta  <= DataRe;
            r_re_s     <= r_re_meta;
        end
    end

    // Storage carries no reset; pointers and level define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_wr_drop   <= 1'b0;
            r_rdy       <= 1'b0;
            r_was_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
            r_wr_drop   <= wr_en & w_full;
            r_rdy       <= ~w_empty;
            r_was_empty <= w_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_data_out <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (r_re_s) begin
                        r_state <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (!w_empty) begin
                        r_data_out <= r_mem[r_rp];
                    end
                    r_state <= c_DRIVE;
                end
                c_DRIVE: begin
                    if (!r_re_s) begin
                        r_state <= c_IDLE;
                    end else if (w_pop) begin
                        r_state <= c_LOAD;
                    end else if (r_was_empty && !w_empty) begin
                        // FIFO refilled while the MCU waits: present the new head
                        r_data_out <= r_mem[r_rp];
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef DDK_DATA_TX_UNDERRUN_EN
    logic       w_urun;
    logic       r_underrun;
    logic [7:0] r_underrun_cnt;

    assign w_urun = (r_state == c_DRIVE) & r_re_s & w_rise & w_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 8'h00;
        end else if (clr) begin
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 8'h00;
        end else if (w_urun) begin
            r_underrun <= 1'b1;
            if (r_underrun_cnt != 8'hFF) begin
                r_underrun_cnt <= r_underrun_cnt + 8'h01;
            end
        end
    end

    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;
`endif

    assign wr_full  = w_full;
    assign wr_drop  = r_wr_drop;
    assign level    = r_level;
    assign DATA_OUT = r_data_out;
    assign DATA_OE  = (r_state == c_DRIVE);
    assign DataRdy  = r_rdy;

endmodule
`default_nettype wire

// File: doc/ddk_data_tx.md
# ddk_data_tx

Core-to-MCU parallel readback port. It buffers 16-bit words produced inside `ddk_core` (capture or trace results) in a FIFO. The MCU reads them back over the shared `DATA` pad bus with its own strobe pair (`DataRe` level, `DataClk` edge). This is the return path to the existing MCU-to-FPGA `DataClk`/`DataWe` write port: the MCU remains bus master and the FPGA only drives `DATA` while `DataRe` is asserted.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in words; must be a power of 2, minimum 4.
- `WIDTH`, 16: word width; matches the `DATA` pad bus.

Ports:
- `clk`, input, 1: system clock (GLA domain).
- `rst`, input, 1: reset, synchronous, active-low.
- `wr_data`, input, WIDTH: word from core logic.
- `wr_en`, input, 1: push `wr_data` this cycle.
- `wr_full`, output, 1: FIFO full; a push while full is dropped.
- `wr_drop`, output, 1: one-cycle pulse when a push is dropped.
- `level`, output, $clog2(DEPTH)+1: current word count.
- `DataClk`, input, 1: MCU read strobe, asynchronous to `clk`; a rising edge pops one word.
- `DataRe`, input, 1: MCU read enable, asynchronous; level-sensitive.
- `DATA_OUT`, output, WIDTH: word presented to the `DATA` pad buffers.
- `DATA_OE`, output, 1: pad output enable for `DATA`.
- `DataRdy`, output, 1: FIFO non-empty flag for the MCU.
- `underrun`, output, 1: sticky flag. Present only with `DDK_DATA_TX_UNDERRUN_EN`.
- `underrun_cnt`, output, 8: saturating count. Present only with `DDK_DATA_TX_UNDERRUN_EN`.
- `clr`, input, 1: clears `underrun` and `underrun_cnt`. Present only with `DDK_DATA_TX_UNDERRUN_EN`.

## Operation
- **Synchronizers:** `DataClk` and `DataRe` each pass through a 2-flop synchronizer, producing `clk_s` and `re_s`. A third flop on `clk_s` provides edge detection: `rise = clk_s & ~clk_q`.
- **FIFO storage:** circular buffer with `$clog2(DEPTH)`-bit read and write pointers that wrap modulo DEPTH. `level` is a separate counter.
- **Full and empty:** `full` is `level == DEPTH`; `empty` is `level == 0`.
- **Push:** when `wr_en & ~full`, write to `mem[wp]`, increment `wp`, increment `level`. When `wr_en & full`, drop the word and pulse `wr_drop`.
- **FSM states:**
  - IDLE: `DATA_OE = 0`. Go to LOAD when `re_s` is 1.
  - LOAD: `DATA_OUT <= mem[rp]`, or holds its old value if empty. Go to DRIVE.
  - DRIVE: `DATA_OE = 1`.
    - On `rise & ~empty`: pop (`rp++`, `level--`) and go to LOAD.
    - On `rise & empty`: underrun; stay in DRIVE and leave `DATA_OUT` unchanged.
    - When `re_s` is 0: go to IDLE. This check has priority over `rise`.
- **Prefetch on refill:** in DRIVE, if the FIFO was empty last cycle and is non-empty now, `DATA_OUT` reloads from `mem[rp]`.
- **Simultaneous push and pop:** both occur; `level` is unchanged. A push into an empty FIFO at the same time as a `rise` does not pop in that cycle.
- **`DataRdy`:** registered `~empty`.
- **Reset** (`rst = 0` at a clock edge): the following are cleared, including mid-transfer.
  - Pointers and `level` to 0.
  - FSM to IDLE.
  - `DATA_OUT` to `16'h0000`.
  - `DATA_OE`, `DataRdy`, `wr_drop` to 0.
  - `underrun` and `underrun_cnt` to 0.
  - `wr_full` to 0.

## Timing
- **Pop latency:** an async `DataClk` rise is seen by `rise` 2–3 `clk` edges later. The pop takes one cycle and the LOAD update one more.
  - The next word is stable on `DATA_OUT` at most 5 `clk` cycles after the `DataClk` rise.
- **MCU sampling rule:** the MCU samples `DATA` at its `DataClk` rising edge, then waits 6 `clk` cycles or more before the next rising edge.
- **`DataClk` pulse width:** high and low phases must each be at least 3 `clk` cycles.
- **Output enable:**
  - `DATA_OE` asserts 4 cycles after `DataRe` rises (sync, LOAD, DRIVE).
  - `DATA_OE` deasserts 3 cycles after `DataRe` falls.
  - `DataRe` must be held at least 8 cycles before the first `DataClk` rise.
- **Write side:** single cycle. `wr_full` and `level` update on the edge that performs the push or pop.

## Configuration
- **`DDK_DATA_TX_UNDERRUN_EN` defined:**
  - A `rise` while empty in DRIVE sets `underrun`.
  - The same event increments `underrun_cnt`, saturating at 255.
  - `clr = 1` clears both; a `clr` in the same cycle as an underrun event wins.
- **Macro undefined:**
  - The `underrun`, `underrun_cnt` and `clr` ports and their logic are absent.
  - An underrun is silently ignored.

## Test plan
- **Reset:** hold `rst = 0` for 2 cycles with `wr_en = 1` -> `level = 0`, `DATA_OE = 0`, `DATA_OUT = 0000`, `DataRdy = 0`.
- **Basic readback:** push `1111`, `2222`, `3333`; assert `DataRe`; give 3 `DataClk` pulses, each 4 high / 4 low -> MCU samples `1111`, `2222`, `3333` in order; `level` ends at 0; `DataRdy` ends at 0.
- **Full and wrap:** push 17 words `0000..0010` with DEPTH 16 -> `wr_full = 1`, `wr_drop` pulses once on word `0010`; then read 16 words -> values `0000..000F`; pointers have wrapped.
- **Simultaneous push and pop:** with `level = 5`, a `rise` and a `wr_en` in the same cycle -> `level` stays 5 and the data order is preserved.
- **Underrun (macro on):** with the FIFO empty in DRIVE, give 2 `DataClk` pulses -> `underrun = 1`, `underrun_cnt = 2`, `DATA_OUT` unchanged; then `clr` -> both return to 0.
- **Reset mid-read:** drop `rst` while in DRIVE with `level = 3` -> next cycle `DATA_OE = 0` and `level = 0`; after reset, pushing `ABCD` and reading returns `ABCD`.
